// File: rtl/imm_gen.sv
// Registered RV32I immediate generator: decodes opcode, extracts and extends the immediate.
// Latency: 1 cycle from instruction to extImmediate; no combinational path through.
// Backpressure: none; loads every edge with an immediate-bearing opcode, otherwise holds.
//
// Ports:
//   clk          system clock, rising-edge state updates
//   reset        asynchronous active-high clear of the output register
//   instruction  32-bit RV32I instruction word
//   extImmediate registered 32-bit immediate (sign- or zero-extended per format)
module imm_gen (
  input  logic               clk,
  input  logic               reset,
  input  logic        [31:0] instruction,
  output logic signed [31:0] extImmediate
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        sign;
  logic [31:0] imm_nxt;
  logic        imm_load;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign sign   = instruction[31];

  always_comb begin
    imm_nxt  = 32'h0000_0000;
    imm_load = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        imm_nxt  = {{20{sign}}, instruction[31:20]};
        imm_load = 1'b1;
      end
      OP_ALUIMM: begin
        imm_load = 1'b1;
        // Shift-immediates carry an unsigned 5-bit shamt; the upper bits
        // (funct7, e.g. the srai selector) must not leak into the operand.
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          imm_nxt = {27'b0, instruction[24:20]};
        end else begin
          imm_nxt = {{20{sign}}, instruction[31:20]};
        end
      end
      OP_STORE: begin
        imm_nxt  = {{20{sign}}, instruction[31:25], instruction[11:7]};
        imm_load = 1'b1;
      end
      OP_BRANCH: begin
        // 13-bit byte offset, LSB always zero.
        imm_nxt  = {{19{sign}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
        imm_load = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_nxt  = {instruction[31:12], 12'b0};
        imm_load = 1'b1;
      end
      OP_JAL: begin
        // 21-bit byte offset, LSB always zero.
        imm_nxt  = {{11{sign}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
        imm_load = 1'b1;
      end
      default: begin
        // R-type, system and undefined opcodes leave the register untouched.
        imm_nxt  = 32'h0000_0000;
        imm_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      extImmediate <= 32'sh0000_0000;
    end else if (imm_load) begin
      extImmediate <= imm_nxt;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed instructions plus randomized
// instruction words, compared against an arithmetic reference model.
module tb_imm_gen;

  logic               clk;
  logic               reset;
  logic        [31:0] instruction;
  logic signed [31:0] extImmediate;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_imm;

  imm_gen dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .extImmediate (extImmediate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Interpret an unsigned field of 'bits' width as two's complement.
  function automatic int sext(input int raw, input int bits);
    if (raw >= (1 << (bits - 1))) return raw - (1 << bits);
    return raw;
  endfunction

  // Reference: value the immediate register should hold after an edge with 'ins',
  // given it held 'prev' before.
  function automatic logic [31:0] model_imm(input logic [31:0] ins, input logic [31:0] prev);
    int v;
    logic [31:0] u;
    case (ins[6:0])
      7'b0000011, 7'b1100111: v = sext(int'(ins[31:20]), 12);
      7'b0010011: begin
        if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) v = int'(ins[24:20]);
        else v = sext(int'(ins[31:20]), 12);
      end
      7'b0100011: v = sext(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
      7'b1100011: v = sext(int'(ins[31]) * 4096 + int'(ins[7]) * 2048
                           + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13);
      7'b1101111: v = sext(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12)
                           + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2, 21);
      7'b0110111, 7'b0010111: begin
        u = (ins >> 12) << 12;
        return u;
      end
      default: return prev;
    endcase
    return 32'(v);
  endfunction

  task automatic apply(input string tag, input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    @(posedge clk);
    #1;
    exp_imm = model_imm(ins, exp_imm);
    chk(tag, extImmediate, exp_imm);
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011};

  initial begin
    reset       = 1'b1;
    instruction = 32'h0011_2183;
    exp_imm     = 32'h0;
    #2;
    chk("reset_async", extImmediate, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_over_edges", extImmediate, 32'h0);

    @(negedge clk);
    reset       = 1'b0;
    instruction = 32'h0020_81B3;      // add: nothing loaded yet
    @(posedge clk);
    #1;
    chk("post_reset_noimm", extImmediate, 32'h0);

    apply("lh",   32'h0011_2183);
    chk("lh_const", extImmediate, 32'd1);
    apply("sh",   32'h0262_8223);
    chk("sh_const", extImmediate, 32'd36);
    apply("andi", 32'h0011_7193);
    apply("addi_m1", 32'hFFF0_0093);
    chk("addi_m1_const", extImmediate, 32'hFFFF_FFFF);
    apply("bne",  32'h8211_10E3);
    apply("add_hold", 32'h0020_81B3);
    apply("sll_hold", 32'h0020_91B3);
    apply("lui",  32'hABCD_E0B7);
    chk("lui_const", extImmediate, 32'hABCD_E000);
    apply("jal_all1", 32'hFFFF_F06F);
    chk("jal_const", extImmediate, 32'hFFFF_FFFE);
    apply("slli31", 32'h01F0_9093);
    chk("slli_const", extImmediate, 32'd31);
    apply("srai31", 32'h41F0_D093);
    chk("srai_const", extImmediate, 32'd31);
    apply("jalr_neg", 32'h8000_0067);
    apply("auipc", 32'hFFFF_F017);

    // Changing the instruction between edges must not reach the output.
    #2;
    instruction = 32'h1234_5037;
    #2;
    chk("midcycle_hold", extImmediate, exp_imm);
    @(posedge clk);
    #1;
    exp_imm = model_imm(instruction, exp_imm);
    chk("midcycle_next_edge", extImmediate, exp_imm);

    // Asynchronous reset mid-cycle clears at once; held value is not restored.
    #2;
    reset = 1'b1;
    #1;
    exp_imm = 32'h0;
    chk("reset_midcycle", extImmediate, exp_imm);
    @(negedge clk);
    reset       = 1'b0;
    instruction = 32'h0000_0073;      // ecall: no immediate
    @(posedge clk);
    #1;
    chk("no_restore", extImmediate, exp_imm);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        exp_imm = 32'h0;
        chk("rand_reset", extImmediate, exp_imm);
        #1;
        reset = 1'b0;
      end
      apply("rand", ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
